// File: rtl/ifetch_prefetch.sv
// ============================================================================
//  Module   : ifetch_prefetch
//  Purpose  : Instruction fetch stage. Generates sequential word-aligned fetch
//             addresses, issues them over a valid/ready request channel,
//             gathers in-order responses into a DEPTH-entry prefetch FIFO and
//             presents {instruction, PC} pairs to decode. A redirect flushes
//             the FIFO, retargets fetch and drops in-flight responses.
//  Ports    : clk, reset (async, active-high)
//             redirect_valid / redirect_pc          - fetch retarget
//             imem_req_valid / _ready / _addr       - memory request channel
//             imem_rsp_valid / imem_rsp_data        - in-order responses
//             inst_valid / inst_ready / inst_out / inst_pc - decode channel
//             fifo_count                            - FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [XLEN-1:0]          inst_out,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  logic [XLEN-1:0] tag_mem  [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_nxt;

  // Every in-flight request owns a FIFO slot, so a response can never
  // arrive to a full FIFO.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (state == RUN) && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid;
  assign rsp_drop = (drop != '0);

  // A redirect discards both the response and the decode pop of that cycle.
  assign push = rsp_fire && !rsp_drop && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);

  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? inst_mem[head] : '0;
  assign inst_pc    = inst_valid ? pc_mem[head]   : '0;
  assign fifo_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      // BOOT lasts exactly one cycle, redirect or not.
      state <= RUN;

      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      outstanding <= outstanding_nxt;

      // The tag queue tracks every in-flight request, stale or not, so it is
      // never flushed; dropped responses still retire their tags.
      if (req_fire) tag_wr <= tag_wr + AW'(1);
      if (rsp_fire) tag_rd <= tag_rd + AW'(1);

      if (redirect_valid) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
        // Everything still in flight after this cycle's response is stale.
        drop  <= outstanding_nxt;
      end else begin
        if (rsp_fire && rsp_drop) drop <= drop - CW'(1);
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
    if (push) begin
      inst_mem[tail] <= imem_rsp_data;
      pc_mem[tail]   <= tag_mem[tag_rd];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
// ============================================================================
//  Module   : tb_ifetch_prefetch
//  Purpose  : Self-checking bench for ifetch_prefetch. A behavioural memory
//             returns 0x1000_0000|addr after a programmable latency; directed
//             phases push expected PCs into a scoreboard queue that a monitor
//             pops on every decode handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int lat    = 1;
  int req_cnt = 0;
  int dlv    = 0;

  logic [31:0] sb [$];
  logic [31:0] pa [$];
  int          pd [$];

  ifetch_prefetch #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
  endtask

  // Reset with the given memory latency and decode readiness; leaves reset
  // asserted so the caller can load expectations before releasing it.
  task automatic start(input int l, input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = rdy;
    lat            = l;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
  endtask

  // Memory model: decides at the negedge what the next posedge will see.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa.delete();
        pd.delete();
        req_cnt        = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          pa.push_back(imem_req_addr);
          pd.push_back(cyc + 1 + lat);
          req_cnt++;
        end
        if (pd.size() > 0 && pd[0] <= cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'h1000_0000 | pa[0];
          void'(pa.pop_front());
          void'(pd.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted decode handshake must match the
  // oldest expected PC.
  initial begin : mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        dlv++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL sb_extra: got pc %h, expected no delivery", inst_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", inst_pc, e);
          chk("sb_inst", inst_out, 32'h1000_0000 | e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int cnt;
    int d0;

    // ---- Phase 1: reset values, first-valid latency, streaming --------------
    start(1, 1'b1);
    chk("rst_req_valid",  32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",   imem_req_addr,       32'h0);
    chk("rst_inst_valid", 32'(inst_valid),     32'd0);
    chk("rst_fifo_count", 32'(fifo_count),     32'd0);
    chk("rst_inst_out",   inst_out,            32'h0);
    chk("rst_inst_pc",    inst_pc,             32'h0);
    push_seq(32'h0, 40);
    d0  = dlv;
    rst = 1'b0;
    n   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (inst_valid) begin
        n = i;
        break;
      end
    end
    chk("first_valid_cycle", 32'(n), 32'd3);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (inst_valid) cnt++;
    end
    chk("sustained_valid", 32'(cnt), 32'd8);
    chk("p1_deliveries", 32'((dlv - d0) >= 8), 32'd1);

    // ---- Phase 2: decode stalled, credits limit requests --------------------
    start(1, 1'b0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_req_cnt",    32'(req_cnt),        32'd4);
    chk("stall_fifo_count", 32'(fifo_count),     32'd4);
    chk("stall_req_valid",  32'(imem_req_valid), 32'd0);
    chk("stall_head_pc",    inst_pc,             32'h0);
    chk("stall_head_inst",  inst_out,            32'h1000_0000);
    push_seq(32'h0, 20);
    d0 = dlv;
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drain_deliveries", 32'((dlv - d0) >= 8), 32'd1);

    // ---- Phase 3: latency 3, redirect with 3 outstanding --------------------
    start(3, 1'b1);
    push_seq(32'h200, 16);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    chk("redir_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_fifo_empty", 32'(fifo_count),     32'd0);
    chk("redir_req_valid",  32'(imem_req_valid), 32'd1);
    chk("redir_req_addr",   imem_req_addr,       32'h200);
    d0 = dlv;
    repeat (20) @(posedge clk);
    #1;
    chk("redir_deliveries", 32'((dlv - d0) >= 4), 32'd1);

    // ---- Phase 4: redirect coinciding with response and decode pop ----------
    start(1, 1'b1);
    push_seq(32'h0, 1);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sb.delete();
    push_seq(32'h300, 24);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    chk("coinc_inst_valid", 32'(inst_valid),     32'd1);
    chk("coinc_rsp_valid",  32'(imem_rsp_valid), 32'd1);
    chk("coinc_no_req",     32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("coinc_fifo_count", 32'(fifo_count),     32'd0);
    chk("coinc_inst_empty", 32'(inst_valid),     32'd0);
    chk("coinc_req_addr",   imem_req_addr,       32'h300);
    repeat (10) @(posedge clk);
    #1;

    // ---- Phase 5: fetch address wrap ----------------------------------------
    sb.delete();
    push_seq(32'hFFFF_FFFC, 24);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_next_addr",  imem_req_addr, 32'h0000_0000);
    d0 = dlv;
    repeat (10) @(posedge clk);
    #1;
    chk("wrap_deliveries", 32'((dlv - d0) >= 6), 32'd1);

    // ---- Phase 6: reset with entries buffered and requests in flight --------
    start(3, 1'b0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_fifo_count", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_inst_valid", 32'(inst_valid),     32'd0);
    chk("mid_rst_fifo_count", 32'(fifo_count),     32'd0);
    chk("mid_rst_req_valid",  32'(imem_req_valid), 32'd0);
    chk("mid_rst_inst_out",   inst_out,            32'h0);
    chk("mid_rst_req_addr",   imem_req_addr,       32'h0);
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    lat        = 1;
    inst_ready = 1'b1;
    push_seq(32'h0, 16);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_req_addr",  imem_req_addr,       32'h0);
    d0 = dlv;
    repeat (10) @(posedge clk);
    #1;
    chk("restart_deliveries", 32'((dlv - d0) >= 6), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
